ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM; all SRAM strobes, address and data drive are
// registered. Define RAM_ARB_FIXED_PRIORITY_EN for fixed port-0 priority (default: round-robin).
module ram_arbiter #(
    parameter int unsigned AWIDTH = 16,
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk,
    input  logic              MR,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic              busy,
    output logic              _ram_oe,
    output logic              _ram_we,
    output logic [AWIDTH-1:0] ram_a,
    inout  wire  [DWIDTH-1:0] ram_d
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              last_q, last_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata0_d, rdata1_d;
    logic              drive_q, drive_d;
    logic              oe_n_d, we_n_d, ack0_d, ack1_d, busy_d;
    logic              grant;

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0;
        rdata1_d = rdata1;
        grant    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
                    grant = req1 & ~req0;
`else
                    // On contention the port not served last wins
                    grant = req1 & (~req0 | ~last_q);
`endif
                    port_d  = grant;
                    last_d  = grant;
                    addr_d  = grant ? addr1 : addr0;
                    wdata_d = grant ? wdata1 : wdata0;
                    state_d = (grant ? we1 : we0) ? StWrSetup : StRdAddr;
                end
            end
            StRdAddr:  state_d = StRdData;
            StRdData: begin
                state_d = StDone;
                if (port_q) rdata1_d = ram_d;
                else        rdata0_d = ram_d;
            end
            StWrSetup: state_d = StWrPulse;
            StWrPulse: state_d = StWrHold;
            StWrHold:  state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so the registers present them glitch-free
        oe_n_d  = !(state_d inside {StRdAddr, StRdData});
        we_n_d  = (state_d != StWrPulse);
        drive_d = (state_d inside {StWrSetup, StWrPulse, StWrHold});
        ack0_d  = (state_d == StDone) && !port_d;
        ack1_d  = (state_d == StDone) && port_d;
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge MR) begin
        if (MR) begin
            state_q <= StIdle;
            port_q  <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
            drive_q <= 1'b0;
            _ram_oe <= 1'b1;
            _ram_we <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata0  <= rdata0_d;
            rdata1  <= rdata1_d;
            drive_q <= drive_d;
            _ram_oe <= oe_n_d;
            _ram_we <= we_n_d;
            ack0    <= ack0_d;
            ack1    <= ack1_d;
            busy    <= busy_d;
        end
    end

    assign ram_a = addr_q;
    assign ram_d = drive_q ? wdata_q : {DWIDTH{1'bz}};

endmodule
